// File: rtl/cpu_pkg.sv
// Shared CPU-side types: address word, AXI response codes and the R-channel entry.
package cpu_pkg;

    localparam int AXI_RESP_W = 2;

    typedef logic [63:0] double_word;

    typedef enum logic [AXI_RESP_W-1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_e;

    typedef struct packed {
        logic [31:0] data;
        axi_resp_e   resp;
    } r_entry_t;

endpackage

// File: rtl/axil_interface_if.sv
// AXI-Lite read-address and read-data channels, with master and slave views.
interface axil_interface_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [AXI_RESP_W-1:0] rresp;

    modport rd_slv (input arvalid, araddr, rready, output arready, rvalid, rdata, rresp);
    modport rd_mst (output arvalid, araddr, rready, input arready, rvalid, rdata, rresp);
endinterface

// File: rtl/axil_r_skid_fifo.sv
// Two-entry circular buffer for R-channel responses; 1-bit pointers toggle on push/pop.
module axil_r_skid_fifo
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  r_entry_t   push_entry,
    input  logic       pop,
    output r_entry_t   head,
    output logic       empty,
    output logic       full,
    output logic [1:0] count
);
    r_entry_t   slot_q [2];
    r_entry_t   slot_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    assign empty   = (count_q == 2'd0);
    assign full    = (count_q == 2'd2);
    assign count   = count_q;
    assign head    = slot_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_comb begin
                slot_d[gi] = slot_q[gi];
                if (do_push && (wr_ptr_q == 1'(gi))) begin
                    slot_d[gi] = push_entry;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_q[gi] <= '0;
                end else begin
                    slot_q[gi] <= slot_d[gi];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/axil_imem_responder.sv
// AXI-Lite read slave serving 32-bit instruction words from an inferred RAM with a side load port.
module axil_imem_responder
    import cpu_pkg::*;
#(
    parameter int                 DEPTH_WORDS = 1024,
    parameter int                 ADDR_W      = 64,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
    parameter string              INIT_FILE   = ""
) (
    input  logic                           clk,
    input  logic                           rst,
    axil_interface_if.rd_slv               mem_rd,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [31:0]                    ld_data
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    generate
        if ($bits(mem_rd.rdata) != 32) begin : g_bad_data_w
            $error("axil_imem_responder: mem_rd DATA_W must be 32");
        end
        if ((1 << IDX_W) != DEPTH_WORDS) begin : g_bad_depth
            $error("axil_imem_responder: DEPTH_WORDS must be a power of two");
        end
    endgenerate

    logic [ADDR_W-1:0] araddr;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] word_off;
    logic              rd_err;
    logic              ar_hs;
    logic              r_hs;
    logic              rready;
    logic              rvalid;

    logic              arready_q, arready_d;
    logic              inflight_q, inflight_d;
    logic              err_q, err_d;
    logic [1:0]        occ_q, occ_d;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [31:0]       ram_rd_q;

    r_entry_t          inflight_entry;
    r_entry_t          fifo_head;
    r_entry_t          r_out;
    logic              fifo_push, fifo_pop;
    logic              fifo_empty, fifo_full;
    logic [1:0]        fifo_count;

    assign araddr   = mem_rd.araddr;
    assign rready   = mem_rd.rready;
    assign off      = araddr - BASE_ADDR;
    assign word_off = off >> 2;
    assign rd_err   = (araddr[1:0] != 2'b00) || (araddr < BASE_ADDR)
                   || (word_off >= ADDR_W'(DEPTH_WORDS));
    assign ar_hs    = mem_rd.arvalid && arready_q;

    // Read-first: a same-edge load does not affect the word captured here.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        if (ar_hs && !rd_err) begin
            ram_rd_q <= mem[word_off[IDX_W-1:0]];
        end
    end

    always_comb begin
        inflight_entry.data = err_q ? 32'h0 : ram_rd_q;
        inflight_entry.resp = err_q ? SLVERR : OKAY;
    end

    // The in-flight word is shown directly when the buffer is empty, so a lone read costs one cycle.
    assign rvalid    = (fifo_count != 2'd0) || inflight_q;
    assign r_hs      = rvalid && rready;
    assign fifo_pop  = !fifo_empty && rready;
    assign fifo_push = inflight_q && !fifo_full && !(fifo_empty && rready);
    assign r_out     = fifo_empty ? inflight_entry : fifo_head;

    axil_r_skid_fifo u_r_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (inflight_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (fifo_count)
    );

    always_comb begin
        inflight_d = ar_hs;
        err_d      = ar_hs && rd_err;
        occ_d      = occ_q + 2'(ar_hs) - 2'(r_hs);
        arready_d  = (occ_d < 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arready_q  <= 1'b0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            arready_q  <= arready_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            occ_q      <= occ_d;
        end
    end

    assign mem_rd.arready = arready_q;
    assign mem_rd.rvalid  = rvalid;
    assign mem_rd.rdata   = rvalid ? r_out.data : 32'h0;
    assign mem_rd.rresp   = rvalid ? r_out.resp : OKAY;

endmodule

// File: tb/tb_axil_imem_responder.sv
// Directed bench for axil_imem_responder: reset, streaming, backpressure, errors, collision, mid-burst reset.
module tb_axil_imem_responder;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    int          n_cmp = 0;
    int          n_mis = 0;

    axil_interface_if #(.ADDR_W(64), .DATA_W(32)) bus ();

    axil_imem_responder #(
        .DEPTH_WORDS (1024),
        .ADDR_W      (64),
        .BASE_ADDR   (64'h0),
        .INIT_FILE   ("")
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mem_rd  (bus.rd_slv),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_r(input string tag, input logic [31:0] exp_data, input axi_resp_e exp_resp);
        $display("R %s: rvalid=%0b rdata=%08h rresp=%0b", tag, bus.rvalid, bus.rdata, bus.rresp);
        check({tag, ".rvalid"}, 64'(bus.rvalid), 64'd1);
        check({tag, ".rdata"}, 64'(bus.rdata), 64'(exp_data));
        check({tag, ".rresp"}, 64'(bus.rresp), 64'(exp_resp));
    endtask

    task automatic load(input logic [9:0] idx, input logic [31:0] word);
        ld_en   = 1'b1;
        ld_addr = idx;
        ld_data = word;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_seq [4];
        exp_seq[0] = 32'd11; exp_seq[1] = 32'd22; exp_seq[2] = 32'd33; exp_seq[3] = 32'd44;

        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        bus.arvalid = 1'b1;
        bus.araddr  = 64'h0;
        bus.rready  = 1'b1;

        // 1: reset held with arvalid asserted
        repeat (3) begin
            @(negedge clk);
            check("rst.arready", 64'(bus.arready), 64'd0);
            check("rst.rvalid", 64'(bus.rvalid), 64'd0);
        end
        rst         = 1'b0;
        bus.arvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post_rst.rvalid", 64'(bus.rvalid), 64'd0);
        end
        check("post_rst.arready", 64'(bus.arready), 64'd1);

        load(10'd0, 32'd11);
        load(10'd1, 32'd22);
        load(10'd2, 32'd33);
        load(10'd3, 32'd44);
        load(10'd1023, 32'hDEAD_BEEF);

        // 2: back-to-back reads at full throughput
        bus.rready  = 1'b1;
        bus.arvalid = 1'b1;
        bus.araddr  = 64'h0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check_r($sformatf("stream%0d", i - 1), exp_seq[i - 1], OKAY);
            check("stream.arready", 64'(bus.arready), 64'd1);
            if (i < 4) bus.araddr = 64'(4 * i);
            else       bus.arvalid = 1'b0;
        end
        @(negedge clk);
        check("stream.idle", 64'(bus.rvalid), 64'd0);

        // 3: backpressure
        bus.rready  = 1'b0;
        bus.arvalid = 1'b1;
        bus.araddr  = 64'h0;
        @(negedge clk);
        check("bp.arready1", 64'(bus.arready), 64'd1);
        check_r("bp.hold0", 32'd11, OKAY);
        bus.araddr = 64'h4;
        @(negedge clk);
        check("bp.arready2", 64'(bus.arready), 64'd0);
        check_r("bp.hold1", 32'd11, OKAY);
        bus.araddr = 64'h8;
        repeat (2) begin
            @(negedge clk);
            check("bp.arready_full", 64'(bus.arready), 64'd0);
            check_r("bp.hold2", 32'd11, OKAY);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        check_r("bp.second", 32'd22, OKAY);
        check("bp.arready_back", 64'(bus.arready), 64'd1);
        @(negedge clk);
        check_r("bp.third", 32'd33, OKAY);
        bus.arvalid = 1'b0;
        @(negedge clk);
        check("bp.idle", 64'(bus.rvalid), 64'd0);

        // 4: decode errors and boundaries
        bus.arvalid = 1'b1;
        bus.araddr  = 64'h2;
        @(negedge clk);
        check_r("err.misaligned", 32'h0, SLVERR);
        bus.araddr = 64'h1000;
        @(negedge clk);
        check_r("err.past_end", 32'h0, SLVERR);
        bus.araddr = 64'h8000_0000_0000_0000;
        @(negedge clk);
        check_r("err.high_addr", 32'h0, SLVERR);
        bus.araddr = 64'hFFC;
        @(negedge clk);
        check_r("ok.last_word", 32'hDEAD_BEEF, OKAY);
        bus.araddr = 64'h4;
        @(negedge clk);
        check_r("ok.after_err", 32'd22, OKAY);
        bus.arvalid = 1'b0;

        // 5: load/read collision on the same word
        bus.arvalid = 1'b1;
        bus.araddr  = 64'h4;
        ld_en       = 1'b1;
        ld_addr     = 10'd1;
        ld_data     = 32'hAA;
        @(negedge clk);
        ld_en = 1'b0;
        check_r("coll.old", 32'd22, OKAY);
        @(negedge clk);
        check_r("coll.new", 32'hAA, OKAY);
        bus.arvalid = 1'b0;
        @(negedge clk);
        check("coll.idle", 64'(bus.rvalid), 64'd0);

        // 6: asynchronous reset with two responses outstanding
        bus.rready  = 1'b0;
        bus.arvalid = 1'b1;
        bus.araddr  = 64'h0;
        @(negedge clk);
        check_r("mid.first", 32'd11, OKAY);
        bus.araddr = 64'h4;
        @(negedge clk);
        check("mid.arready_full", 64'(bus.arready), 64'd0);
        bus.arvalid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid.rvalid_async", 64'(bus.rvalid), 64'd0);
        check("mid.arready_async", 64'(bus.arready), 64'd0);
        check("mid.rdata_async", 64'(bus.rdata), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid.post_rvalid", 64'(bus.rvalid), 64'd0);
        check("mid.post_arready", 64'(bus.arready), 64'd1);
        bus.rready  = 1'b1;
        bus.arvalid = 1'b1;
        bus.araddr  = 64'hC;
        @(negedge clk);
        check_r("mid.fresh", 32'd44, OKAY);
        bus.arvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("mid.no_stale", 64'(bus.rvalid), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
